// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT frame sequencer.
//   FFTPTS_W        : width of the transform-size field
//   sched_state_e   : sequencer state encoding (IDLE / RUN)
//   is_legal_fftpts : true for the power-of-two sizes 16..2048 the IFFT supports
package idct_pkg;

  localparam int FFTPTS_W = 12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  function automatic logic is_legal_fftpts(input logic [FFTPTS_W-1:0] pts);
    logic ok;
    case (pts)
      12'd16, 12'd32, 12'd64, 12'd128,
      12'd256, 12'd512, 12'd1024, 12'd2048: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/idct_frame_sched_if.sv
// Bus bundle between the frame sequencer and its surroundings.
//   cfg_*     : per-frame transform-size command and illegal-size pulse
//   up_*      : unframed upstream sample stream
//   fft_*     : framed IFFT sink stream with sop/eop and held fftpts
//   mon_*     : observation of the scaling stage output
//   inflight  : frames issued but not yet seen at the scaling output
//   ovf_rpt_* : per-frame saturation report
// slave  : the sequencer side.  master : the environment side.
interface idct_frame_sched_if #(
  parameter int wData   = 16,
  parameter int wOvfCnt = 12
);
  import idct_pkg::*;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [FFTPTS_W-1:0] cfg_fftpts;
  logic                cfg_err;
  logic                up_valid;
  logic                up_ready;
  logic [wData-1:0]    up_real;
  logic [wData-1:0]    up_imag;
  logic                fft_valid;
  logic                fft_ready;
  logic                fft_sop;
  logic                fft_eop;
  logic [wData-1:0]    fft_real;
  logic [wData-1:0]    fft_imag;
  logic [FFTPTS_W-1:0] fft_fftpts;
  logic                mon_valid;
  logic                mon_sop;
  logic                mon_eop;
  logic                mon_overflow;
  logic [2:0]          inflight;
  logic                ovf_rpt_valid;
  logic [wOvfCnt-1:0]  ovf_rpt_cnt;

  modport slave (
    input  cfg_valid, cfg_fftpts, up_valid, up_real, up_imag, fft_ready,
           mon_valid, mon_sop, mon_eop, mon_overflow,
    output cfg_ready, cfg_err, up_ready, fft_valid, fft_sop, fft_eop,
           fft_real, fft_imag, fft_fftpts, inflight, ovf_rpt_valid, ovf_rpt_cnt
  );

  modport master (
    output cfg_valid, cfg_fftpts, up_valid, up_real, up_imag, fft_ready,
           mon_valid, mon_sop, mon_eop, mon_overflow,
    input  cfg_ready, cfg_err, up_ready, fft_valid, fft_sop, fft_eop,
           fft_real, fft_imag, fft_fftpts, inflight, ovf_rpt_valid, ovf_rpt_cnt
  );

endinterface

// File: rtl/idct_ovf_frame_cnt.sv
// Per-frame overflow counter on the scaling stage output.
//   clk, rst_sync      : clock, synchronous active-high reset
//   mon_*_i            : scaling stage valid/sop/eop/overflow
//   ovf_rpt_valid_o    : one-cycle pulse after each eop sample
//   ovf_rpt_cnt_o      : saturated count of overflow samples in that frame
module idct_ovf_frame_cnt #(
  parameter int wOvfCnt = 12
) (
  input  logic               clk,
  input  logic               rst_sync,
  input  logic               mon_valid_i,
  input  logic               mon_sop_i,
  input  logic               mon_eop_i,
  input  logic               mon_overflow_i,
  output logic               ovf_rpt_valid_o,
  output logic [wOvfCnt-1:0] ovf_rpt_cnt_o
);

  localparam logic [wOvfCnt-1:0] ACC_MAX = '1;
  localparam logic [wOvfCnt-1:0] ACC_ONE = {{(wOvfCnt-1){1'b0}}, 1'b1};

  function automatic logic [wOvfCnt-1:0] sat_inc(input logic [wOvfCnt-1:0] acc,
                                                 input logic inc);
    logic [wOvfCnt-1:0] res;
    if (inc && (acc != ACC_MAX)) begin
      res = acc + ACC_ONE;
    end else begin
      res = acc;
    end
    return res;
  endfunction

  logic [wOvfCnt-1:0] acc_q, acc_d;
  logic [wOvfCnt-1:0] rpt_cnt_q, rpt_cnt_d;
  logic               rpt_valid_q, rpt_valid_d;

  // Accumulate overflow flags; sop restarts the count with its own flag so a
  // single-sample frame reports exactly that sample.
  always_comb begin
    acc_d       = acc_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_valid_d = 1'b0;
    if (mon_valid_i) begin
      if (mon_sop_i) begin
        acc_d = {{(wOvfCnt-1){1'b0}}, mon_overflow_i};
      end else begin
        acc_d = sat_inc(acc_q, mon_overflow_i);
      end
      if (mon_eop_i) begin
        rpt_cnt_d   = acc_d;
        rpt_valid_d = 1'b1;
      end else begin
        rpt_valid_d = 1'b0;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator and report registers.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      acc_q       <= '0;
      rpt_cnt_q   <= '0;
      rpt_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_valid_q <= rpt_valid_d;
    end
  end

  assign ovf_rpt_valid_o = rpt_valid_q;
  assign ovf_rpt_cnt_o   = rpt_cnt_q;

endmodule

// File: rtl/idct_frame_sched.sv
// Frame sequencer in front of the IDCT IFFT + scaling chain.
//   clk, rst_sync : clock, synchronous active-high reset
//   bus (slave)   : command, upstream, IFFT sink, monitor and report signals
// Accepts one size command per frame, frames the upstream stream with
// sop/eop, holds fftpts for the frame, and tracks frames in flight up to
// MAX_INFLIGHT.
module idct_frame_sched
  import idct_pkg::*;
#(
  parameter int wData        = 16,
  parameter int MAX_INFLIGHT = 4,
  parameter int wOvfCnt      = 12
) (
  input logic               clk,
  input logic               rst_sync,
  idct_frame_sched_if.slave bus
);

  localparam logic [2:0] MAX_INF = 3'(MAX_INFLIGHT);

  sched_state_e        state_q, state_d;
  logic [FFTPTS_W-1:0] cnt_q, cnt_d;
  logic [FFTPTS_W-1:0] fftpts_q, fftpts_d;
  logic [2:0]          inflight_q, inflight_d;
  logic                cfg_err_q, cfg_err_d;

  logic cfg_ready_s, fft_valid_s, up_ready_s, last_s, frame_done_s, dec_s;

  // Samples pass straight through at the sink width; fft_valid alone gates them.
  logic [wData-1:0] real_s, imag_s;
  assign real_s = bus.up_real;
  assign imag_s = bus.up_imag;

  assign last_s = (cnt_q == (fftpts_q - 12'd1));

  // Sequencer: command accept in IDLE, sample framing in RUN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fftpts_d     = fftpts_q;
    cfg_err_d    = 1'b0;
    cfg_ready_s  = 1'b0;
    fft_valid_s  = 1'b0;
    up_ready_s   = 1'b0;
    frame_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready_s = (inflight_q < MAX_INF);
        if (bus.cfg_valid && cfg_ready_s) begin
          if (is_legal_fftpts(bus.cfg_fftpts)) begin
            fftpts_d = bus.cfg_fftpts;
            cnt_d    = 12'd0;
            state_d  = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          cfg_err_d = 1'b0;
        end
      end
      ST_RUN: begin
        fft_valid_s = bus.up_valid;
        up_ready_s  = bus.fft_ready;
        if (fft_valid_s && bus.fft_ready) begin
          if (last_s) begin
            cnt_d        = 12'd0;
            frame_done_s = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frames in flight: +1 on an issued eop, -1 on a monitored eop (never below 0).
  always_comb begin
    dec_s      = bus.mon_valid && bus.mon_eop && (inflight_q != 3'd0);
    inflight_d = inflight_q;
    case ({frame_done_s, dec_s})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Sequencer, counter and inflight registers.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 12'd0;
      fftpts_q   <= 12'd0;
      inflight_q <= 3'd0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fftpts_q   <= fftpts_d;
      inflight_q <= inflight_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign bus.cfg_ready  = cfg_ready_s;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.up_ready   = up_ready_s;
  assign bus.fft_valid  = fft_valid_s;
  assign bus.fft_sop    = fft_valid_s & (cnt_q == 12'd0);
  assign bus.fft_eop    = fft_valid_s & last_s;
  assign bus.fft_real   = real_s;
  assign bus.fft_imag   = imag_s;
  assign bus.fft_fftpts = fftpts_q;
  assign bus.inflight   = inflight_q;

  idct_ovf_frame_cnt #(
    .wOvfCnt(wOvfCnt)
  ) u_ovf (
    .clk             (clk),
    .rst_sync        (rst_sync),
    .mon_valid_i     (bus.mon_valid),
    .mon_sop_i       (bus.mon_sop),
    .mon_eop_i       (bus.mon_eop),
    .mon_overflow_i  (bus.mon_overflow),
    .ovf_rpt_valid_o (bus.ovf_rpt_valid),
    .ovf_rpt_cnt_o   (bus.ovf_rpt_cnt)
  );

endmodule

// File: tb/tb_idct_frame_sched.sv
// Randomized self-checking bench for idct_frame_sched against a frame-level
// reference model (frame size, position in frame, frames in flight, overflow tally).
module tb_idct_frame_sched;

  localparam int MAXI   = 4;
  localparam int ACCMAX = 4095;

  logic clk;
  logic rst_sync;

  idct_frame_sched_if #(.wData(16), .wOvfCnt(12)) bus ();

  idct_frame_sched #(.wData(16), .MAX_INFLIGHT(MAXI), .wOvfCnt(12)) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit m_run;
  int m_pos, m_size, m_infl, m_acc, m_rpt_cnt;
  bit m_err, m_rpt_v;

  // observations of the current frame (from sampled DUT outputs)
  int obs_xfer, obs_eop_cnt, obs_eop_idx, obs_sop_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit size_ok(input int s);
    return (s >= 16) && (s <= 2048) && ($countones(s) == 1);
  endfunction

  task automatic obs_clear();
    obs_xfer = 0; obs_eop_cnt = 0; obs_eop_idx = -1; obs_sop_idx = -1;
  endtask

  task automatic compare();
    bit fv;
    fv = m_run && bus.up_valid;
    chk("cfg_ready",     32'(bus.cfg_ready),     32'(!m_run && (m_infl < MAXI)));
    chk("up_ready",      32'(bus.up_ready),      32'(m_run && bus.fft_ready));
    chk("fft_valid",     32'(bus.fft_valid),     32'(fv));
    chk("fft_sop",       32'(bus.fft_sop),       32'(fv && (m_pos == 0)));
    chk("fft_eop",       32'(bus.fft_eop),       32'(fv && (m_pos == m_size - 1)));
    chk("fft_fftpts",    32'(bus.fft_fftpts),    32'(m_size));
    chk("fft_real",      32'(bus.fft_real),      32'(bus.up_real));
    chk("fft_imag",      32'(bus.fft_imag),      32'(bus.up_imag));
    chk("inflight",      32'(bus.inflight),      32'(m_infl));
    chk("cfg_err",       32'(bus.cfg_err),       32'(m_err));
    chk("ovf_rpt_valid", 32'(bus.ovf_rpt_valid), 32'(m_rpt_v));
    chk("ovf_rpt_cnt",   32'(bus.ovf_rpt_cnt),   32'(m_rpt_cnt));
    if (bus.fft_valid && bus.fft_ready) begin
      if (bus.fft_sop && (obs_sop_idx < 0)) obs_sop_idx = obs_xfer;
      obs_xfer++;
      if (bus.fft_eop) begin
        obs_eop_cnt++;
        obs_eop_idx = obs_xfer;
      end
    end
  endtask

  task automatic model_update();
    bit acc_ok, legal, xf, last, dec;
    int ovf;
    if (rst_sync) begin
      m_run = 0; m_pos = 0; m_size = 0; m_infl = 0;
      m_err = 0; m_acc = 0; m_rpt_cnt = 0; m_rpt_v = 0;
    end else begin
      acc_ok = !m_run && bus.cfg_valid && (m_infl < MAXI);
      legal  = size_ok(int'(bus.cfg_fftpts));
      xf     = m_run && bus.up_valid && bus.fft_ready;
      last   = xf && (m_pos == m_size - 1);
      dec    = bus.mon_valid && bus.mon_eop && (m_infl > 0);
      m_infl = m_infl + (last ? 1 : 0) - (dec ? 1 : 0);
      m_err  = acc_ok && !legal;
      if (acc_ok && legal) begin
        m_size = int'(bus.cfg_fftpts); m_pos = 0; m_run = 1;
      end else if (xf) begin
        if (last) begin m_pos = 0; m_run = 0; end
        else m_pos++;
      end
      m_rpt_v = 0;
      if (bus.mon_valid) begin
        ovf = bus.mon_overflow ? 1 : 0;
        if (bus.mon_sop) m_acc = ovf;
        else m_acc = (m_acc + ovf > ACCMAX) ? ACCMAX : m_acc + ovf;
        if (bus.mon_eop) begin m_rpt_cnt = m_acc; m_rpt_v = 1; end
      end
    end
  endtask

  // one clock: check settled outputs, advance model at the edge, return at negedge
  task automatic cycle();
    #1;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic mon_idle();
    bus.mon_valid = 0; bus.mon_sop = 0; bus.mon_eop = 0; bus.mon_overflow = 0;
  endtask

  task automatic drive_mon(input int mode);
    if (mode == 2) begin
      bus.mon_valid    = 1'($urandom_range(0, 1));
      bus.mon_sop      = 1'($urandom_range(0, 1));
      bus.mon_eop      = 1'($urandom_range(0, 3) == 0);
      bus.mon_overflow = 1'($urandom_range(0, 1));
    end else begin
      mon_idle();
    end
  endtask

  task automatic drive_data();
    bus.up_real = 16'($urandom);
    bus.up_imag = 16'($urandom);
  endtask

  // mode 0: always valid/ready; 1: ready toggles each cycle; 2: everything random
  task automatic run_frame(input int size, input int mode, input bit coincide, input bit check);
    int guard, budget;
    bit legal;
    legal = size_ok(size);
    bus.cfg_fftpts = 12'(size);
    bus.cfg_valid  = 1;
    bus.up_valid   = 0;
    bus.fft_ready  = 0;
    guard = 0;
    while (!(!m_run && (m_infl < MAXI)) && (guard < 400)) begin
      drive_mon(mode); drive_data(); cycle(); guard++;
    end
    if (guard >= 400) chk("cfg_wait_timeout", 32'd1, 32'd0);
    drive_mon(mode); drive_data(); cycle();
    bus.cfg_valid = 0;
    if (!legal) return;
    obs_clear();
    budget = size * 4 + 64;
    guard = 0;
    while (m_run && (guard < budget)) begin
      case (mode)
        0:       begin bus.up_valid = 1; bus.fft_ready = 1; end
        1:       begin bus.up_valid = 1; bus.fft_ready = 1'(guard % 2 == 0); end
        default: begin bus.up_valid = 1'($urandom_range(0, 1));
                       bus.fft_ready = 1'($urandom_range(0, 1)); end
      endcase
      drive_data();
      drive_mon(mode);
      if (coincide && bus.up_valid && bus.fft_ready && (m_pos == m_size - 1)) begin
        bus.mon_valid = 1; bus.mon_eop = 1; bus.mon_sop = 0; bus.mon_overflow = 0;
      end
      cycle();
      guard++;
    end
    if (guard >= budget) chk("frame_timeout", 32'd1, 32'd0);
    mon_idle();
    if (check) begin
      chk("frame_xfers",   32'(obs_xfer),    32'(size));
      chk("frame_eops",    32'(obs_eop_cnt), 32'd1);
      chk("frame_eop_idx", 32'(obs_eop_idx), 32'(size));
      chk("frame_sop_idx", 32'(obs_sop_idx), 32'd0);
      bus.up_valid = 1; bus.fft_ready = 1;
      #1;
      chk("up_ready_after_eop", 32'(bus.up_ready), 32'd0);
    end
    bus.up_valid = 0; bus.fft_ready = 0;
  endtask

  task automatic mon_frame(input int len, input logic [31:0] mask);
    for (int i = 0; i < len; i++) begin
      bus.mon_valid    = 1;
      bus.mon_sop      = 1'(i == 0);
      bus.mon_eop      = 1'(i == len - 1);
      bus.mon_overflow = mask[i];
      cycle();
    end
    mon_idle();
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_infl > 0) && (guard < 16)) begin
      bus.mon_valid = 1; bus.mon_sop = 1; bus.mon_eop = 1; bus.mon_overflow = 0;
      cycle(); guard++;
    end
    mon_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int infl0;
    int sizes[8] = '{16, 32, 64, 100, 16, 48, 0, 32};
    rst_sync = 1;
    bus.cfg_valid = 0; bus.cfg_fftpts = 0; bus.up_valid = 0; bus.fft_ready = 0;
    bus.up_real = 0; bus.up_imag = 0;
    mon_idle();
    obs_clear();
    repeat (2) @(posedge clk);
    model_update();
    @(negedge clk);
    rst_sync = 0;
    #1;
    chk("rst_inflight",   32'(bus.inflight),      32'd0);
    chk("rst_fftpts",     32'(bus.fft_fftpts),    32'd0);
    chk("rst_cfg_ready",  32'(bus.cfg_ready),     32'd1);
    chk("rst_ovf_valid",  32'(bus.ovf_rpt_valid), 32'd0);
    chk("rst_ovf_cnt",    32'(bus.ovf_rpt_cnt),   32'd0);

    // first frame of 16, full throughput
    infl0 = m_infl;
    run_frame(16, 0, 0, 1);
    chk("infl_after_16", 32'(bus.inflight), 32'(infl0 + 1));

    // illegal size: error pulse, size held, then a legal command goes through
    run_frame(100, 0, 0, 0);
    #1;
    chk("cfg_err_100",     32'(bus.cfg_err),    32'd1);
    chk("fftpts_hold_100", 32'(bus.fft_fftpts), 32'd16);
    chk("idle_after_100",  32'(bus.cfg_ready),  32'd1);
    run_frame(64, 0, 0, 1);
    chk("fftpts_64", 32'(bus.fft_fftpts), 32'd64);

    // largest frame under a stalling sink
    run_frame(2048, 1, 0, 1);

    // inflight limit
    drain();
    for (int f = 0; f < 4; f++) run_frame(16, 0, 0, 1);
    #1;
    chk("infl_full",       32'(bus.inflight),  32'd4);
    chk("cfg_ready_full",  32'(bus.cfg_ready), 32'd0);
    bus.mon_valid = 1; bus.mon_sop = 1; bus.mon_eop = 1;
    cycle();
    mon_idle();
    #1;
    chk("infl_after_mon",  32'(bus.inflight),  32'd3);
    chk("cfg_ready_room",  32'(bus.cfg_ready), 32'd1);
    run_frame(16, 0, 1, 1);
    chk("infl_coincide", 32'(bus.inflight), 32'd3);

    // overflow reporting
    mon_frame(32, 32'h8000_0021);
    #1;
    chk("ovf_rpt_valid_3", 32'(bus.ovf_rpt_valid), 32'd1);
    chk("ovf_rpt_cnt_3",   32'(bus.ovf_rpt_cnt),   32'd3);
    cycle();
    chk("ovf_rpt_pulse_end", 32'(bus.ovf_rpt_valid), 32'd0);
    mon_frame(32, 32'h0000_0000);
    #1;
    chk("ovf_rpt_cnt_0", 32'(bus.ovf_rpt_cnt), 32'd0);
    mon_frame(1, 32'h0000_0001);
    #1;
    chk("ovf_rpt_single", 32'(bus.ovf_rpt_cnt), 32'd1);

    // reset in the middle of a frame
    drain();
    bus.cfg_fftpts = 12'd64; bus.cfg_valid = 1;
    cycle();
    bus.cfg_valid = 0;
    obs_clear();
    for (int g = 0; (g < 40) && (obs_xfer < 7); g++) begin
      bus.up_valid = 1; bus.fft_ready = 1; drive_data(); cycle();
    end
    chk("mid_xfers", 32'(obs_xfer), 32'd7);
    rst_sync = 1;
    cycle();
    rst_sync = 0;
    bus.up_valid = 0;
    #1;
    chk("mid_rst_fftpts",   32'(bus.fft_fftpts), 32'd0);
    chk("mid_rst_inflight", 32'(bus.inflight),   32'd0);
    chk("mid_rst_valid",    32'(bus.fft_valid),  32'd0);
    chk("mid_rst_cfg_rdy",  32'(bus.cfg_ready),  32'd1);
    run_frame(64, 0, 0, 1);

    // random frames with random monitor traffic
    for (int k = 0; k < 24; k++) begin
      run_frame(sizes[$urandom_range(0, 7)], 2, 0, 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
